// File: rtl/output_driver_pkg.sv
// ---------------------------------------------------------------------------
// output_driver_pkg
// Definitions shared by the pulse burst driver and its per-channel engine:
//   - cfgOpT      : meaning of the 2-bit cfgOp field
//   - CTRL_*      : bit positions inside a CONTROL payload
//   - chanStateT  : per-channel waveform state encoding
// No ports; imported by output_pulse_channel and output_pulse_burst_driver.
// ---------------------------------------------------------------------------
package output_driver_pkg;

  typedef enum logic [1:0] {
    OP_CONTROL = 2'd0,
    OP_DELAY   = 2'd1,
    OP_WIDTH   = 2'd2,
    OP_PERIOD  = 2'd3
  } cfgOpT;

  localparam int CTRL_ENABLE_BIT = 0;
  localparam int CTRL_INVERT_BIT = 1;
  localparam int CTRL_BURST_LSB  = 8;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DELAY = 3'd1,
    S_FIRST = 3'd2,
    S_HIGH  = 3'd3,
    S_LAST  = 3'd4,
    S_GAP   = 3'd5
  } chanStateT;

endpackage

// File: rtl/output_pulse_channel.sv
// ---------------------------------------------------------------------------
// output_pulse_channel
// One output channel: shadow/active configuration, commit handling and the
// waveform FSM that turns a trigger into a burst of SERDES words.
// Ports:
//   evrClk, evrRst_n : EVR clock, asynchronous active-low reset
//   cfgWrite         : configuration write aimed at this channel (one cycle)
//   cfgOp, cfgData   : operation code and payload of that write
//   trigger          : one-cycle trigger strobe
//   busy             : registered, high while the channel is not idle
//   pattern          : registered SERDES word, LSB transmitted first
// ---------------------------------------------------------------------------
module output_pulse_channel
  import output_driver_pkg::*;
#(
  parameter int SERDES_WIDTH       = 4,
  parameter int COARSE_DELAY_WIDTH = 22,
  parameter int COARSE_WIDTH_WIDTH = 20,
  parameter int PERIOD_WIDTH       = 20,
  parameter int BURST_COUNT_WIDTH  = 8
) (
  input  logic                    evrClk,
  input  logic                    evrRst_n,
  input  logic                    cfgWrite,
  input  logic [1:0]              cfgOp,
  input  logic [31:0]             cfgData,
  input  logic                    trigger,
  output logic                    busy,
  output logic [SERDES_WIDTH-1:0] pattern
);

  // Effective period must hold both the period field and coarseWidth+2.
  localparam int EXT_WIDTH = (PERIOD_WIDTH > COARSE_WIDTH_WIDTH + 1) ?
                             PERIOD_WIDTH : COARSE_WIDTH_WIDTH + 1;

  localparam logic [COARSE_DELAY_WIDTH:0] DELAY_ONE  = 1;
  localparam logic [COARSE_WIDTH_WIDTH:0] WIDTH_ONE  = 1;
  localparam logic [EXT_WIDTH:0]          PERIOD_ONE = 1;
  localparam logic [BURST_COUNT_WIDTH:0]  BURST_ONE  = 1;
  localparam logic [EXT_WIDTH-1:0]        WIDTH_PAD  = 2;

  logic [COARSE_DELAY_WIDTH-1:0] shDelay, acDelay;
  logic [COARSE_WIDTH_WIDTH-1:0] shWidth, acWidth;
  logic [PERIOD_WIDTH-1:0]       shPeriod, acPeriod;
  logic [SERDES_WIDTH-1:0]       shFirst, acFirst, shLast, acLast;
  logic [BURST_COUNT_WIDTH-1:0]  shBurst, acBurst;
  logic                          shEnable, acEnable, shInvert, acInvert;
  logic                          commitPending;

  chanStateT                     state;
  logic [COARSE_DELAY_WIDTH:0]   delayCnt, delayNext, delayLoad;
  logic [COARSE_WIDTH_WIDTH:0]   widthCnt, widthNext, widthLoad;
  logic [EXT_WIDTH:0]            periodCnt, periodNext, periodLoad;
  logic [BURST_COUNT_WIDTH:0]    burstCnt, burstNext, burstLoad;

  logic                          ctrlWrite, applyCommit;
  logic                          commitEnable, commitInvert;
  logic [BURST_COUNT_WIDTH-1:0]  commitBurst;
  logic [EXT_WIDTH-1:0]          widthPlusTwo, periodExt, periodEff;
  logic [SERDES_WIDTH-1:0]       idleWord, highWord, firstWord, lastWord;
  logic                          unusedCfgBits;

  assign unusedCfgBits = ^cfgData;

  // Commit decode, output words and counter load/decrement values.
  // Counters carry one extra MSB: they load value-1 and a stage ends when
  // the decremented value sets the MSB, so all-ones fields never wrap.
  // A CONTROL write with enable=0 aborts a running burst at once; any
  // other commit only takes effect while idle.
  always_comb begin
    ctrlWrite    = cfgWrite && (cfgOp == OP_CONTROL);
    commitEnable = ctrlWrite ? cfgData[CTRL_ENABLE_BIT] : shEnable;
    commitInvert = ctrlWrite ? cfgData[CTRL_INVERT_BIT] : shInvert;
    commitBurst  = ctrlWrite ? cfgData[CTRL_BURST_LSB +: BURST_COUNT_WIDTH] : shBurst;
    applyCommit  = (state == S_IDLE) ? (ctrlWrite || commitPending)
                                     : (ctrlWrite && !cfgData[CTRL_ENABLE_BIT]);

    widthPlusTwo = EXT_WIDTH'(acWidth) + WIDTH_PAD;
    periodExt    = EXT_WIDTH'(acPeriod);
    periodEff    = (periodExt > widthPlusTwo) ? periodExt : widthPlusTwo;

    idleWord     = {SERDES_WIDTH{acInvert}};
    highWord     = {SERDES_WIDTH{~acInvert}};
    firstWord    = acFirst ^ idleWord;
    lastWord     = acLast ^ idleWord;

    delayLoad    = {1'b0, acDelay} - DELAY_ONE;
    widthLoad    = {1'b0, acWidth} - WIDTH_ONE;
    periodLoad   = {1'b0, periodEff} - PERIOD_ONE;
    burstLoad    = (acBurst == '0) ? '0 : ({1'b0, acBurst} - BURST_ONE);

    delayNext    = delayCnt - DELAY_ONE;
    widthNext    = widthCnt - WIDTH_ONE;
    periodNext   = periodCnt - PERIOD_ONE;
    burstNext    = burstCnt - BURST_ONE;
  end

  // Configuration shadows, commit into the active set, and the waveform FSM.
  // The period counter starts at each firstPattern and runs through the
  // pulse, so whatever remains at S_LAST is the gap before the next pulse.
  always_ff @(posedge evrClk or negedge evrRst_n) begin
    if (!evrRst_n) begin
      shDelay       <= '0;
      shFirst       <= '0;
      shWidth       <= '0;
      shLast        <= '0;
      shPeriod      <= '0;
      shBurst       <= '0;
      shEnable      <= 1'b0;
      shInvert      <= 1'b0;
      acDelay       <= '0;
      acFirst       <= '0;
      acWidth       <= '0;
      acLast        <= '0;
      acPeriod      <= '0;
      acBurst       <= '0;
      acEnable      <= 1'b0;
      acInvert      <= 1'b0;
      commitPending <= 1'b0;
      state         <= S_IDLE;
      delayCnt      <= '0;
      widthCnt      <= '0;
      periodCnt     <= '0;
      burstCnt      <= '0;
      busy          <= 1'b0;
      pattern       <= '0;
    end else begin
      if (cfgWrite) begin
        case (cfgOp)
          OP_DELAY: begin
            shDelay <= cfgData[SERDES_WIDTH +: COARSE_DELAY_WIDTH];
            shFirst <= cfgData[0 +: SERDES_WIDTH];
          end
          OP_WIDTH: begin
            shWidth <= cfgData[SERDES_WIDTH +: COARSE_WIDTH_WIDTH];
            shLast  <= cfgData[0 +: SERDES_WIDTH];
          end
          OP_PERIOD: shPeriod <= cfgData[0 +: PERIOD_WIDTH];
          default: begin
            shEnable <= cfgData[CTRL_ENABLE_BIT];
            shInvert <= cfgData[CTRL_INVERT_BIT];
            shBurst  <= cfgData[CTRL_BURST_LSB +: BURST_COUNT_WIDTH];
          end
        endcase
      end

      if (applyCommit) begin
        acDelay       <= shDelay;
        acFirst       <= shFirst;
        acWidth       <= shWidth;
        acLast        <= shLast;
        acPeriod      <= shPeriod;
        acEnable      <= commitEnable;
        acInvert      <= commitInvert;
        acBurst       <= commitBurst;
        commitPending <= 1'b0;
        state         <= S_IDLE;
        busy          <= 1'b0;
        pattern       <= {SERDES_WIDTH{commitInvert}};
      end else begin
        if (ctrlWrite && (state != S_IDLE)) begin
          commitPending <= 1'b1;
        end
        case (state)
          S_IDLE: begin
            pattern <= idleWord;
            if (trigger && acEnable) begin
              busy     <= 1'b1;
              burstCnt <= burstLoad;
              if (acDelay == '0) begin
                state     <= S_FIRST;
                pattern   <= firstWord;
                widthCnt  <= widthLoad;
                periodCnt <= periodLoad;
              end else begin
                state    <= S_DELAY;
                delayCnt <= delayLoad;
              end
            end
          end
          S_DELAY: begin
            if (delayNext[COARSE_DELAY_WIDTH]) begin
              state     <= S_FIRST;
              pattern   <= firstWord;
              widthCnt  <= widthLoad;
              periodCnt <= periodLoad;
            end else begin
              delayCnt <= delayNext;
              pattern  <= idleWord;
            end
          end
          S_FIRST: begin
            periodCnt <= periodNext;
            if (acWidth == '0) begin
              state   <= S_LAST;
              pattern <= lastWord;
            end else begin
              state   <= S_HIGH;
              pattern <= highWord;
            end
          end
          S_HIGH: begin
            periodCnt <= periodNext;
            if (widthNext[COARSE_WIDTH_WIDTH]) begin
              state   <= S_LAST;
              pattern <= lastWord;
            end else begin
              widthCnt <= widthNext;
              pattern  <= highWord;
            end
          end
          S_LAST: begin
            if (burstNext[BURST_COUNT_WIDTH]) begin
              state   <= S_IDLE;
              busy    <= 1'b0;
              pattern <= idleWord;
            end else begin
              burstCnt <= burstNext;
              if (periodNext[EXT_WIDTH]) begin
                state     <= S_FIRST;
                pattern   <= firstWord;
                widthCnt  <= widthLoad;
                periodCnt <= periodLoad;
              end else begin
                state     <= S_GAP;
                periodCnt <= periodNext;
                pattern   <= idleWord;
              end
            end
          end
          S_GAP: begin
            if (periodNext[EXT_WIDTH]) begin
              state     <= S_FIRST;
              pattern   <= firstWord;
              widthCnt  <= widthLoad;
              periodCnt <= periodLoad;
            end else begin
              periodCnt <= periodNext;
              pattern   <= idleWord;
            end
          end
          default: begin
            state   <= S_IDLE;
            busy    <= 1'b0;
            pattern <= idleWord;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/output_pulse_burst_driver.sv
// ---------------------------------------------------------------------------
// output_pulse_burst_driver
// Multi-channel event-triggered pulse burst generator in the EVR domain.
// Ports:
//   evrClk, evrRst_n : EVR clock, asynchronous active-low reset
//   cfgStrobe        : one-cycle configuration write qualifier
//   cfgChannel       : target channel (writes to absent channels are dropped)
//   cfgOp, cfgData   : operation (CONTROL/DELAY/WIDTH/PERIOD) and payload
//   triggerStrobe    : per-channel one-cycle trigger
//   channelBusy      : per-channel busy flag
//   serdesPattern    : channel c on bits [c*SERDES_WIDTH +: SERDES_WIDTH]
// ---------------------------------------------------------------------------
module output_pulse_burst_driver
  import output_driver_pkg::*;
#(
  parameter int CHANNEL_COUNT      = 4,
  parameter int SERDES_WIDTH       = 4,
  parameter int COARSE_DELAY_WIDTH = 22,
  parameter int COARSE_WIDTH_WIDTH = 20,
  parameter int PERIOD_WIDTH       = 20,
  parameter int BURST_COUNT_WIDTH  = 8
) (
  input  logic                                  evrClk,
  input  logic                                  evrRst_n,
  input  logic                                  cfgStrobe,
  input  logic [$clog2(CHANNEL_COUNT)-1:0]      cfgChannel,
  input  logic [1:0]                            cfgOp,
  input  logic [31:0]                           cfgData,
  input  logic [CHANNEL_COUNT-1:0]              triggerStrobe,
  output logic [CHANNEL_COUNT-1:0]              channelBusy,
  output logic [CHANNEL_COUNT*SERDES_WIDTH-1:0] serdesPattern
);

  logic [CHANNEL_COUNT-1:0] chanWrite;

  // One engine per channel; the shared cfg port is steered by cfgChannel.
  for (genvar c = 0; c < CHANNEL_COUNT; c++) begin : gChannel
    assign chanWrite[c] = cfgStrobe && (32'(cfgChannel) == c);

    output_pulse_channel #(
      .SERDES_WIDTH      (SERDES_WIDTH),
      .COARSE_DELAY_WIDTH(COARSE_DELAY_WIDTH),
      .COARSE_WIDTH_WIDTH(COARSE_WIDTH_WIDTH),
      .PERIOD_WIDTH      (PERIOD_WIDTH),
      .BURST_COUNT_WIDTH (BURST_COUNT_WIDTH)
    ) uChannel (
      .evrClk  (evrClk),
      .evrRst_n(evrRst_n),
      .cfgWrite(chanWrite[c]),
      .cfgOp   (cfgOp),
      .cfgData (cfgData),
      .trigger (triggerStrobe[c]),
      .busy    (channelBusy[c]),
      .pattern (serdesPattern[c*SERDES_WIDTH +: SERDES_WIDTH])
    );
  end

endmodule

// File: tb/tb_output_pulse_burst_driver.sv
// ---------------------------------------------------------------------------
// tb_output_pulse_burst_driver
// Directed scenarios plus randomized traffic against a reference model that
// computes every channel's expected word and busy flag from the trigger time
// and committed configuration with plain arithmetic.
// ---------------------------------------------------------------------------
module tb_output_pulse_burst_driver;

  localparam int NCH = 4;
  localparam int SW  = 4;

  logic            evrClk = 1'b0;
  logic            evrRst_n;
  logic            cfgStrobe;
  logic [1:0]      cfgChannel;
  logic [1:0]      cfgOp;
  logic [31:0]     cfgData;
  logic [NCH-1:0]  triggerStrobe;
  logic [NCH-1:0]  channelBusy;
  logic [NCH*SW-1:0] serdesPattern;

  always #5 evrClk = ~evrClk;

  output_pulse_burst_driver dut (
    .evrClk       (evrClk),
    .evrRst_n     (evrRst_n),
    .cfgStrobe    (cfgStrobe),
    .cfgChannel   (cfgChannel),
    .cfgOp        (cfgOp),
    .cfgData      (cfgData),
    .triggerStrobe(triggerStrobe),
    .channelBusy  (channelBusy),
    .serdesPattern(serdesPattern)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Reference model state: shadow and committed configuration per channel
  int shD[NCH], shF[NCH], shW[NCH], shL[NCH], shP[NCH], shEn[NCH], shInv[NCH], shN[NCH];
  int acD[NCH], acF[NCH], acW[NCH], acL[NCH], acP[NCH], acEn[NCH], acInv[NCH], acN[NCH];
  int pend[NCH];
  // Running burst described by its trigger time and frozen parameters
  int bActive[NCH], bTrig[NCH], bD[NCH], bF[NCH], bW[NCH], bL[NCH], bN[NCH], bP[NCH];
  int bInv[NCH], bEnd[NCH];

  logic [3:0] hWord [0:8191];
  logic       hBusy [0:8191];

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, observed, expected);
    end
  endtask

  function automatic int expWord(int ch, int x);
    int w, rel, k, r;
    if (bActive[ch] == 0 || x > bEnd[ch]) return (acInv[ch] != 0) ? 15 : 0;
    w = 0;
    rel = x - (bTrig[ch] + bD[ch] + 1);
    if (rel >= 0) begin
      k = rel / bP[ch];
      r = rel % bP[ch];
      if (k < bN[ch]) begin
        if (r == 0) w = bF[ch];
        else if (r <= bW[ch]) w = 15;
        else if (r == bW[ch] + 1) w = bL[ch];
      end
    end
    return (bInv[ch] != 0) ? (w ^ 15) : w;
  endfunction

  function automatic int expBusy(int ch, int x);
    return (bActive[ch] != 0 && x <= bEnd[ch]) ? 1 : 0;
  endfunction

  task automatic modelReset();
    for (int c = 0; c < NCH; c++) begin
      shD[c] = 0; shF[c] = 0; shW[c] = 0; shL[c] = 0; shP[c] = 0; shEn[c] = 0; shInv[c] = 0; shN[c] = 0;
      acD[c] = 0; acF[c] = 0; acW[c] = 0; acL[c] = 0; acP[c] = 0; acEn[c] = 0; acInv[c] = 0; acN[c] = 0;
      pend[c] = 0; bActive[c] = 0; bEnd[c] = 0;
    end
  endtask

  task automatic modelUpdate(input bit strobe, input int ch, input int op,
                             input logic [31:0] data, input logic [NCH-1:0] trig);
    for (int c = 0; c < NCH; c++) begin
      int busyNow, isWr, isCtrl, doCommit, cEn, cInv, cN;
      isWr   = (strobe && ch == c) ? 1 : 0;
      isCtrl = (isWr != 0 && op == 0) ? 1 : 0;
      busyNow = expBusy(c, cyc);
      if (busyNow == 0) bActive[c] = 0;
      cEn = shEn[c]; cInv = shInv[c]; cN = shN[c];
      if (isCtrl != 0) begin
        cEn = int'(data[0]); cInv = int'(data[1]); cN = int'(data[15:8]);
      end
      doCommit = 0;
      if (busyNow == 0) begin
        if (isCtrl != 0 || pend[c] != 0) doCommit = 1;
        else if (trig[c] && acEn[c] != 0) begin
          bActive[c] = 1; bTrig[c] = cyc;
          bD[c] = acD[c]; bF[c] = acF[c]; bW[c] = acW[c]; bL[c] = acL[c]; bInv[c] = acInv[c];
          bN[c] = (acN[c] == 0) ? 1 : acN[c];
          bP[c] = (acP[c] > acW[c] + 2) ? acP[c] : acW[c] + 2;
          bEnd[c] = cyc + bD[c] + 1 + (bN[c] - 1) * bP[c] + bW[c] + 1;
        end
      end else if (isCtrl != 0) begin
        if (cEn == 0) begin
          bActive[c] = 0;
          doCommit = 1;
        end else pend[c] = 1;
      end
      if (doCommit != 0) begin
        acD[c] = shD[c]; acF[c] = shF[c]; acW[c] = shW[c]; acL[c] = shL[c]; acP[c] = shP[c];
        acEn[c] = cEn; acInv[c] = cInv; acN[c] = cN; pend[c] = 0;
      end
      if (isWr != 0) begin
        case (op)
          1: begin shD[c] = int'(data[25:4]); shF[c] = int'(data[3:0]); end
          2: begin shW[c] = int'(data[23:4]); shL[c] = int'(data[3:0]); end
          3: shP[c] = int'(data[19:0]);
          default: begin shEn[c] = cEn; shInv[c] = cInv; shN[c] = cN; end
        endcase
      end
    end
  endtask

  task automatic checkAll();
    for (int c = 0; c < NCH; c++) begin
      checkOutput($sformatf("ch%0d word", c), 32'(serdesPattern[c*SW +: SW]), 32'(expWord(c, cyc)));
      checkOutput($sformatf("ch%0d busy", c), 32'(channelBusy[c]), 32'(expBusy(c, cyc)));
    end
    if (cyc < 8192) begin
      hWord[cyc] = serdesPattern[3:0];
      hBusy[cyc] = channelBusy[0];
    end
  endtask

  // One clock: check the current cycle, then drive and model this cycle's inputs
  task automatic applyStimulus(input bit strobe, input int ch, input int op,
                               input logic [31:0] data, input logic [NCH-1:0] trig);
    @(posedge evrClk);
    #1;
    cyc++;
    checkAll();
    cfgStrobe     = strobe;
    cfgChannel    = 2'(ch);
    cfgOp         = 2'(op);
    cfgData       = data;
    triggerStrobe = trig;
    modelUpdate(strobe, ch, op, data, trig);
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 0, 0, 32'h0, '0);
  endtask

  task automatic writeCfg(input int ch, input int op, input int data);
    applyStimulus(1'b1, ch, op, 32'(data), '0);
  endtask

  task automatic configure(input int ch, input int d, input int f, input int w, input int l,
                           input int p, input int en, input int inv, input int n);
    writeCfg(ch, 1, (d << 4) | f);
    writeCfg(ch, 2, (w << 4) | l);
    writeCfg(ch, 3, p);
    writeCfg(ch, 0, en | (inv << 1) | (n << 8));
    idleCycles(3);
  endtask

  task automatic fire(input logic [NCH-1:0] trig, output int t);
    applyStimulus(1'b0, 0, 0, 32'h0, trig);
    t = cyc;
  endtask

  initial begin
    int t, t2, a;
    modelReset();
    evrRst_n = 1'b0;
    cfgStrobe = 1'b0; cfgChannel = '0; cfgOp = '0; cfgData = '0; triggerStrobe = '0;
    #1;
    checkOutput("reset pattern", 32'(serdesPattern), 32'h0);
    checkOutput("reset busy", 32'(channelBusy), 32'h0);
    @(posedge evrClk); @(posedge evrClk);
    #3 evrRst_n = 1'b1;

    // Single pulse: D=3, W=2, first 1100, last 0011
    configure(0, 3, 'hC, 2, 'h3, 0, 1, 0, 1);
    fire(4'b0001, t);
    idleCycles(12);
    checkOutput("t1 first", 32'(hWord[t+4]), 32'hC);
    checkOutput("t1 high1", 32'(hWord[t+5]), 32'hF);
    checkOutput("t1 high2", 32'(hWord[t+6]), 32'hF);
    checkOutput("t1 last", 32'(hWord[t+7]), 32'h3);
    checkOutput("t1 idle after", 32'(hWord[t+8]), 32'h0);
    checkOutput("t1 busy start", 32'(hBusy[t+1]), 32'h1);
    checkOutput("t1 busy end", 32'(hBusy[t+7]), 32'h1);
    checkOutput("t1 busy drop", 32'(hBusy[t+8]), 32'h0);

    // Burst N=3, P=10 with an ignored retrigger
    configure(0, 3, 'hC, 2, 'h3, 10, 1, 0, 3);
    fire(4'b0001, t);
    idleCycles(4);
    fire(4'b0001, t2);
    idleCycles(28);
    checkOutput("t2 pulse2", 32'(hWord[t+14]), 32'hC);
    checkOutput("t2 pulse3", 32'(hWord[t+24]), 32'hC);
    checkOutput("t2 busy last", 32'(hBusy[t+27]), 32'h1);
    checkOutput("t2 busy drop", 32'(hBusy[t+28]), 32'h0);

    // P below W+2, inverted output
    configure(0, 3, 'hC, 2, 'h3, 1, 1, 1, 2);
    fire(4'b0001, t);
    idleCycles(14);
    checkOutput("t3 idle inv", 32'(hWord[t+2]), 32'hF);
    checkOutput("t3 first inv", 32'(hWord[t+4]), 32'h3);
    checkOutput("t3 high inv", 32'(hWord[t+5]), 32'h0);
    checkOutput("t3 last inv", 32'(hWord[t+7]), 32'hC);
    checkOutput("t3 back2back", 32'(hWord[t+8]), 32'h3);

    // Deferred commit while busy, then abort
    configure(0, 3, 'hC, 2, 'h3, 10, 1, 0, 3);
    fire(4'b0001, t);
    idleCycles(5);
    writeCfg(0, 1, (1 << 4) | 'hC);
    writeCfg(0, 0, 1 | (3 << 8));
    idleCycles(25);
    checkOutput("t4 deferred", 32'(hWord[t+14]), 32'hC);
    fire(4'b0001, t);
    idleCycles(6);
    checkOutput("t4 new delay", 32'(hWord[t+2]), 32'hC);
    writeCfg(0, 0, 0);
    a = cyc;
    idleCycles(4);
    checkOutput("t4 abort busy", 32'(hBusy[a+1]), 32'h0);
    checkOutput("t4 abort word", 32'(hWord[a+1]), 32'h0);

    // Simultaneous triggers on ch0 and ch3 with different configuration
    configure(0, 2, 'h6, 1, 'h1, 0, 1, 0, 1);
    configure(3, 5, 'h9, 1, 'h6, 0, 1, 1, 2);
    fire(4'b1001, t);
    idleCycles(20);

    // Boundaries: D=0, W=0, P=0, N=255 on ch2; N=0 on ch1
    configure(2, 0, 'h5, 0, 'hA, 0, 1, 0, 255);
    configure(1, 0, 'h7, 0, 'h8, 0, 1, 0, 0);
    fire(4'b0110, t);
    idleCycles(515);

    // Asynchronous reset in S_HIGH
    configure(1, 1, 'h3, 8, 'h1, 0, 1, 1, 1);
    fire(4'b0010, t);
    idleCycles(4);
    #2 evrRst_n = 1'b0;
    #1;
    checkOutput("async reset pattern", 32'(serdesPattern), 32'h0);
    checkOutput("async reset busy", 32'(channelBusy), 32'h0);
    modelReset();
    @(posedge evrClk); @(posedge evrClk);
    #3 evrRst_n = 1'b1;
    fire(4'b1111, t);
    idleCycles(10);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bit strobe;
      int ch, op, data;
      logic [NCH-1:0] trig;
      strobe = ($urandom_range(0, 7) == 0);
      ch = $urandom_range(0, NCH-1);
      op = $urandom_range(0, 3);
      case (op)
        1: data = ($urandom_range(0, 6) << 4) | $urandom_range(0, 15);
        2: data = ($urandom_range(0, 4) << 4) | $urandom_range(0, 15);
        3: data = $urandom_range(0, 12);
        default: data = (($urandom_range(0, 3) != 0) ? 1 : 0) |
                        ((($urandom_range(0, 3) == 0) ? 1 : 0) << 1) |
                        ($urandom_range(0, 3) << 8);
      endcase
      for (int c = 0; c < NCH; c++) trig[c] = ($urandom_range(0, 5) == 0);
      applyStimulus(strobe, ch, op, 32'(data), trig);
    end
    idleCycles(60);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
